// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake receive buffer.
// Holds the receiver FSM encoding and the synchronizer depth.
package hs_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_rx_state_t;

  localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_fifo.sv
// Generic FIFO with first-word fall-through read; push/pop take effect on the clock edge.
// Pushes while full and pops while empty are dropped, so the caller must check full/empty.
module hs_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // level is kept apart from the pointers so full and empty never alias
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/hs_rx_buffer.sv
// 4-phase sync/ack slave feeding a FIFO drained over valid/ready; push and ack one edge after sync_s.
// Holds ack low while full; HS_RX_SYNC_EN adds a 2-flop synchronizer on sync (+2 clocks latency).
module hs_rx_buffer
  import hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sync,
  output logic                     ack,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level
);

  hs_rx_state_t state;
  hs_rx_state_t state_nxt;
  logic         sync_s;
  logic         push;
  logic         full;
  logic         empty;

`ifdef HS_RX_SYNC_EN
  logic [HS_SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[HS_SYNC_STAGES-2:0], sync};
    end
  end

  assign sync_s = sync_ff[HS_SYNC_STAGES-1];
`else
  assign sync_s = sync;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= HS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // full comes from the registered level, so a same-cycle pop cannot admit a push
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      HS_IDLE: begin
        if (sync_s && !full) begin
          push      = 1'b1;
          state_nxt = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!sync_s) begin
          state_nxt = HS_IDLE;
        end
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  assign ack       = (state == HS_ACK);
  assign out_valid = !empty;

  hs_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (data_in),
    .pop       (out_ready && out_valid),
    .pop_data  (out_data),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_hs_rx_buffer.sv
// Bench for hs_rx_buffer: handshake master stimulus with a queue scoreboard on the output stream.
// Expected words are queued when a transfer is issued; a negedge monitor checks every pop.
module tb_hs_rx_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef HS_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clock;
  logic             reset_n;
  logic             sync;
  logic             ack;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LW-1:0]    level;

  logic [WIDTH-1:0] exp_q[$];
  int               errors;
  int               checks;
  int               rx_count;

  hs_rx_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sync      (sync),
    .ack       (ack),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input logic val, input string name);
    for (int i = 0; i < 50; i++) begin
      if (ack === val) break;
      tick();
    end
    check(name, {31'b0, ack}, {31'b0, val});
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 100; i++) begin
      if (level == '0) break;
      tick();
    end
    check(name, {29'b0, level}, 32'd0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    data_in = w;
    sync    = 1'b1;
    exp_q.push_back(w);
    tick();
    wait_ack(1'b1, "send_ack_rise");
    sync = 1'b0;
    wait_ack(1'b0, "send_ack_fall");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: a pop happens at the next edge whenever valid and ready are both high
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_data, 32'hxxxx_xxxx);
      end else begin
        check("out_word", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    rx_count  = 0;
    sync      = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_data", out_data, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single word with consumer ready
    out_ready = 1'b1;
    data_in   = 32'hDEADBEEF;
    sync      = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < LAT; i++) begin
      tick();
      check("single_ack_early", {31'b0, ack}, 32'd0);
    end
    tick();
    check("single_ack", {31'b0, ack}, 32'd1);
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_data", out_data, 32'hDEADBEEF);
    check("single_level", {29'b0, level}, 32'd1);
    sync = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check("single_ack_hold", {31'b0, ack}, 32'd1);
    end
    tick();
    check("single_ack_fall", {31'b0, ack}, 32'd0);
    wait_empty("single_drain");

    // Fill to DEPTH, then back-pressure a fifth transfer
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      send_word(32'h100 + i);
    end
    check("fill_level", {29'b0, level}, 32'd4);
    data_in = 32'h55;
    sync    = 1'b1;
    exp_q.push_back(32'h55);
    repeat (10) tick();
    check("full_ack_held", {31'b0, ack}, 32'd0);
    check("full_level", {29'b0, level}, 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_level", {29'b0, level}, 32'd3);
    check("pop_ack_not_yet", {31'b0, ack}, 32'd0);
    tick();
    check("refill_ack", {31'b0, ack}, 32'd1);
    check("refill_level", {29'b0, level}, 32'd4);
    sync = 1'b0;
    wait_ack(1'b0, "refill_ack_fall");
    out_ready = 1'b1;
    wait_empty("fill_drain");

    // Wrap-around: ten words with the consumer toggling ready
    rx_count = 0;
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int w = 0; w < 10; w++) begin
            send_word(w);
          end
          done = 1'b1;
        end
        begin
          for (int c = 0; c < 2000 && !done; c++) begin
            out_ready = ~out_ready;
            tick();
          end
        end
      join
    end
    out_ready = 1'b1;
    wait_empty("wrap_drain");
    tick();
    check("wrap_count", rx_count, 32'd10);
    check("wrap_queue_empty", exp_q.size(), 32'd0);

    // Held sync: one push only
    do_reset();
    out_ready = 1'b0;
    data_in   = 32'hA5A5A5A5;
    sync      = 1'b1;
    exp_q.push_back(32'hA5A5A5A5);
    tick();
    wait_ack(1'b1, "held_ack_rise");
    repeat (20) tick();
    check("held_level", {29'b0, level}, 32'd1);
    check("held_ack", {31'b0, ack}, 32'd1);
    sync = 1'b0;
    wait_ack(1'b0, "held_ack_fall");
    out_ready = 1'b1;
    wait_empty("held_drain");

    // Reset while in HS_ACK with two words stored
    out_ready = 1'b0;
    send_word(32'h11111111);
    data_in = 32'h22222222;
    sync    = 1'b1;
    exp_q.push_back(32'h22222222);
    tick();
    wait_ack(1'b1, "mid_ack_rise");
    check("mid_level", {29'b0, level}, 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, ack}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_level", {29'b0, level}, 32'd0);
    exp_q.delete();
    tick();
    exp_q.push_back(32'h22222222);
    reset_n = 1'b1;
    tick();
    wait_ack(1'b1, "dup_ack_rise");
    check("dup_level", {29'b0, level}, 32'd1);
    sync = 1'b0;
    wait_ack(1'b0, "dup_ack_fall");
    out_ready = 1'b1;
    wait_empty("dup_drain");
    tick();
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_rx_buffer.md
# hs_rx_buffer

- 4-phase handshake slave receiver with an elastic buffer.
- Accepts words from an upstream handshake master (sync/ack protocol) and stores them in a small FIFO.
- Presents them on a valid/ready stream to the downstream consumer, e.g. the UART transmitter that ships measurement words off-chip.
- Decouples the master's transfer rate from the consumer's, and back-pressures the master when full.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sync  in  1  request from handshake master.
- ack  out  1  acknowledge to handshake master.
- data_in  in  WIDTH  word from master; stable while sync=1 and until ack=1 is seen.
- out_data  out  WIDTH  head-of-FIFO word (first-word fall-through).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- level  out  $clog2(DEPTH)+1  current word count, 0..DEPTH.

## Operation
- Reset (reset_n=0, asynchronous): ack=0, out_valid=0, level=0, out_data=0, FIFO pointers=0, FSM=HS_IDLE.
- FSM, 2 states:
  - HS_IDLE: ack=0.
    - If sync_s=1 and level<DEPTH: push data_in, ack<=1, go to HS_ACK.
    - If sync_s=1 and level==DEPTH: hold; no push, ack stays 0 (back-pressure).
  - HS_ACK: ack=1.
    - When sync_s=0: ack<=0, go to HS_IDLE.
    - While sync_s=1: hold; no further push.
- sync_s is sync directly, or the synchronized sync (see Configuration).
- Exactly one push per 4-phase cycle; a sync held high never causes a second push.
- Pop occurs when out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Full test uses the registered level. A pop in the same cycle does not free a slot for that cycle's push; the push happens the next cycle.
- Push and pop in the same cycle (non-full, non-empty): level unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately, so full and empty are unambiguous.
- Reset mid-transfer: the FIFO is flushed and ack drops immediately. If sync is still 1 after release, the word is captured again (a duplicate). The master must be reset together with this block.

## Timing
- Push latency (macro off): sync=1 sampled at edge k. At edge k, the word is written and ack=1. After edge k: out_valid=1 (if the FIFO was empty), out_data valid, level incremented.
- Ack release: sync=0 sampled at edge m gives ack=0 after edge m. The next push is possible at edge m+1 at the earliest.
- Minimum 4-phase cycle against a same-clock master: 4 clocks per word.
- Pop: out_valid=1 and out_ready=1 at edge j. After edge j, the next word (or out_valid=0) and level−1 are presented.
- Outputs are registered except out_data, which is a FIFO memory read at the registered read pointer.

## Configuration
- HS_RX_SYNC_EN
  - Defined: sync passes through a 2-flop synchronizer before the FSM. This adds 2 clocks to both the push and ack-release latency.
  - data_in is not synchronized; the master holds it stable from sync rise until it sees ack=1, per protocol.
  - Both synchronizer flops reset to 0.
- Not defined: sync_s = sync. The master must be in the clock domain.

## Structure
- Package hs_pkg: typedef enum hs_rx_state_t {HS_IDLE, HS_ACK}; localparam HS_SYNC_STAGES=2.
- Sub-module hs_fifo (WIDTH, DEPTH).
  - Ports: clock, reset_n, push, push_data, pop, pop_data, level, full, empty.
  - Instantiated once; the FSM and synchronizer stay in hs_rx_buffer.

## Test plan
- Single word, out_ready=1 (macro off): sync up with data_in=32'hDEADBEEF.
  - ack=1 and out_valid=1 with out_data=32'hDEADBEEF one edge later.
  - ack=0 one edge after sync drops.
- Fill, DEPTH=4, out_ready=0: 4 transfers → level=4.
  - 5th sync held high → ack stays 0.
  - Then out_ready=1 for 1 cycle → level=3 and ack=1 on the following edge.
- Wrap-around: 10 words 0..9 through DEPTH=4 with out_ready toggling 1,0 → consumer receives exactly 0..9 in order; no duplicates, no drops.
- Held sync: sync held high 20 cycles after ack → exactly one push (level=1).
- Reset mid-operation: reset_n pulsed low while in HS_ACK with level=2 → immediately ack=0, out_valid=0, level=0. Since sync is still high at release, one new push follows.
- HS_RX_SYNC_EN defined: repeat the single-word test → ack rises 2 clocks later than the macro-off case; data is still correct.
